key_ctrl: RTL and testbench

Front-panel key sequencer for the digital watch. It debounces four raw push-buttons and drives the `control` block's mode and set inputs: the `set`/`alerm` levels, one-cycle `minute_set`/`hour_set` pulses with auto-repeat, and the `alerm_switch` toggle. It sits between the board pins and `control`, in the same clock domain.

---
 rtl/key_ctrl_pkg.sv | 33 +++
 rtl/key_debounce.sv | 68 ++++++
 rtl/key_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_key_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_ctrl_pkg.sv
// Shared definitions for the front-panel key sequencer: mode/field encodings
// (RUN=0, SET=1, ALARM=2 as seen by control and the display) and helpers.
package key_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_SET   = 2'd1,
        MODE_ALARM = 2'd2
    } mode_e;

    typedef enum logic {
        FIELD_MIN  = 1'b0,
        FIELD_HOUR = 1'b1
    } field_e;

    // Raw buttons are active-low, so the idle pin level is 1.
    localparam logic        KEY_RELEASED   = 1'b1;
    localparam logic [1:0]  SYNC_WARMUP    = 2'd2;
    localparam logic [1:0]  HOLDOFF_CYCLES = 2'd2;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_RUN: return MODE_SET;
            MODE_SET: return MODE_ALARM;
            default:  return MODE_RUN;
        endcase
    endfunction

    function automatic logic is_edit(input mode_e m);
        return (m == MODE_SET) || (m == MODE_ALARM);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, stability counter, debounced level
// and a one-cycle press event on the accepted released->pressed transition.
module key_debounce
    import key_ctrl_pkg::*;
#(
    parameter logic [15:0] debounce_cnt = 16'd50000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_key,
    output logic o_level,
    output logic o_press
);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_level;
    logic        r_press;
    logic        r_armed;
    logic [1:0]  r_warm;
    logic [15:0] r_cnt;

    logic        w_differs;
    logic        w_done;

    assign w_differs = (r_sync2 != r_level);
    assign w_done    = ({1'b0, r_cnt} + 17'd1) >= {1'b0, debounce_cnt};

    // Events stay disarmed until a genuine released sample follows reset, so a
    // key held through reset must be released before it can fire.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= KEY_RELEASED;
            r_sync2 <= KEY_RELEASED;
            r_level <= KEY_RELEASED;
            r_press <= 1'b0;
            r_armed <= 1'b0;
            r_warm  <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;

            if (r_warm != SYNC_WARMUP) begin
                r_warm <= r_warm + 2'd1;
            end else if (r_sync2 == KEY_RELEASED) begin
                r_armed <= 1'b1;
            end

            if (w_differs) begin
                if (w_done) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    r_press <= r_armed && (r_sync2 != KEY_RELEASED);
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/key_ctrl.sv
// Front-panel key sequencer: debounces four buttons and drives control's
// set/alerm levels, increment pulses with auto-repeat and the alarm enable.
module key_ctrl
    import key_ctrl_pkg::*;
#(
    parameter logic [15:0] debounce_cnt = 16'd50000,
    parameter logic [23:0] repeat_delay = 24'd500000,
    parameter logic [23:0] repeat_rate  = 24'd100000,
    parameter logic [31:0] idle_timeout = 32'd10000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_mode,
    input  logic       key_field,
    input  logic       key_inc,
    input  logic       key_onoff,
    output logic       set,
    output logic       alerm,
    output logic       minute_set,
    output logic       hour_set,
    output logic       alerm_switch,
    output logic [1:0] mode
);

    logic w_ev_mode, w_ev_field, w_ev_inc, w_ev_onoff;
    logic w_lvl_inc;
    logic w_mode_lvl_unused, w_field_lvl_unused, w_onoff_lvl_unused;

    key_debounce #(.debounce_cnt(debounce_cnt)) u_db_mode (
        .clock   (clock),
        .reset   (reset),
        .i_key   (key_mode),
        .o_level (w_mode_lvl_unused),
        .o_press (w_ev_mode)
    );

    key_debounce #(.debounce_cnt(debounce_cnt)) u_db_field (
        .clock   (clock),
        .reset   (reset),
        .i_key   (key_field),
        .o_level (w_field_lvl_unused),
        .o_press (w_ev_field)
    );

    key_debounce #(.debounce_cnt(debounce_cnt)) u_db_inc (
        .clock   (clock),
        .reset   (reset),
        .i_key   (key_inc),
        .o_level (w_lvl_inc),
        .o_press (w_ev_inc)
    );

    key_debounce #(.debounce_cnt(debounce_cnt)) u_db_onoff (
        .clock   (clock),
        .reset   (reset),
        .i_key   (key_onoff),
        .o_level (w_onoff_lvl_unused),
        .o_press (w_ev_onoff)
    );

    mode_e       r_mode;
    field_e      r_field;
    logic        r_set;
    logic        r_alerm;
    logic        r_minute;
    logic        r_hour;
    logic        r_switch;
    logic [1:0]  r_hold;
    logic        r_rpt_active;
    logic        r_rpt_phase;
    logic [23:0] r_rpt_cnt;
    logic [31:0] r_idle;

    mode_e       w_mode_nxt;
    logic        w_mode_chg;
    logic        w_edit;
    logic        w_inc_ok;
    logic        w_held;
    logic        w_any_ev;
    logic        w_timeout;
    logic [23:0] w_rpt_target;
    logic        w_rpt_due;

    assign w_edit       = is_edit(r_mode);
    assign w_inc_ok     = w_edit && (r_hold == 2'd0);
    assign w_held       = (w_lvl_inc != KEY_RELEASED);
    assign w_any_ev     = w_ev_mode || w_ev_field || w_ev_inc || w_ev_onoff;
    assign w_timeout    = w_edit && !w_any_ev && (r_idle >= idle_timeout);
    assign w_rpt_target = r_rpt_phase ? repeat_rate : repeat_delay;
    assign w_rpt_due    = ({1'b0, r_rpt_cnt} + 25'd1) >= {1'b0, w_rpt_target};

    always_comb begin
        w_mode_nxt = r_mode;
        case (r_mode)
            MODE_RUN, MODE_SET, MODE_ALARM: begin
                if (w_ev_mode) begin
                    w_mode_nxt = next_mode(r_mode);
                end else if (w_timeout) begin
                    w_mode_nxt = MODE_RUN;
                end
            end
            default: w_mode_nxt = MODE_RUN;
        endcase
    end

    assign w_mode_chg = (w_mode_nxt != r_mode);

    // A mode change (key, timeout or recovery) pre-empts same-cycle field and
    // increment handling, restarts the hold-off and cancels any repeat.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mode       <= MODE_RUN;
            r_field      <= FIELD_MIN;
            r_set        <= 1'b0;
            r_alerm      <= 1'b0;
            r_minute     <= 1'b0;
            r_hour       <= 1'b0;
            r_switch     <= 1'b0;
            r_hold       <= '0;
            r_rpt_active <= 1'b0;
            r_rpt_phase  <= 1'b0;
            r_rpt_cnt    <= '0;
            r_idle       <= '0;
        end else begin
            r_mode   <= w_mode_nxt;
            r_set    <= (w_mode_nxt == MODE_SET);
            r_alerm  <= (w_mode_nxt == MODE_ALARM);
            r_minute <= 1'b0;
            r_hour   <= 1'b0;

            if (w_ev_onoff) begin
                r_switch <= ~r_switch;
            end

            if (w_mode_nxt == MODE_RUN || w_any_ev) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + 32'd1;
            end

            if (w_mode_chg) begin
                r_field      <= FIELD_MIN;
                r_hold       <= HOLDOFF_CYCLES;
                r_rpt_active <= 1'b0;
            end else begin
                if (r_hold != 2'd0) begin
                    r_hold <= r_hold - 2'd1;
                end

                if (w_ev_field && w_edit) begin
                    r_field <= (r_field == FIELD_MIN) ? FIELD_HOUR : FIELD_MIN;
                end

                if (w_ev_inc && w_inc_ok) begin
                    r_minute     <= (r_field == FIELD_MIN);
                    r_hour       <= (r_field == FIELD_HOUR);
                    r_rpt_active <= 1'b1;
                    r_rpt_phase  <= 1'b0;
                    r_rpt_cnt    <= '0;
                end else if (r_rpt_active) begin
                    if (!w_held) begin
                        r_rpt_active <= 1'b0;
                    end else if (w_rpt_due) begin
                        r_minute    <= (r_field == FIELD_MIN);
                        r_hour      <= (r_field == FIELD_HOUR);
                        r_rpt_phase <= 1'b1;
                        r_rpt_cnt   <= '0;
                    end else begin
                        r_rpt_cnt <= r_rpt_cnt + 24'd1;
                    end
                end
            end
        end
    end

    assign set          = r_set;
    assign alerm        = r_alerm;
    assign minute_set   = r_minute;
    assign hour_set     = r_hour;
    assign alerm_switch = r_switch;
    assign mode         = r_mode;

endmodule

// File: tb/tb_key_ctrl.sv
// Directed bench for key_ctrl with short debounce/repeat/timeout settings.
module tb_key_ctrl;

    logic       clock;
    logic       reset;
    logic       key_mode;
    logic       key_field;
    logic       key_inc;
    logic       key_onoff;
    logic       set;
    logic       alerm;
    logic       minute_set;
    logic       hour_set;
    logic       alerm_switch;
    logic [1:0] mode;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int q_min[$];
    int q_hr[$];
    int exp_rep[5] = '{7, 27, 32, 37, 42};

    key_ctrl #(
        .debounce_cnt (16'd4),
        .repeat_delay (24'd20),
        .repeat_rate  (24'd5),
        .idle_timeout (32'd100)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .key_mode     (key_mode),
        .key_field    (key_field),
        .key_inc      (key_inc),
        .key_onoff    (key_onoff),
        .set          (set),
        .alerm        (alerm),
        .minute_set   (minute_set),
        .hour_set     (hour_set),
        .alerm_switch (alerm_switch),
        .mode         (mode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n cycles, sampling on the falling edge and logging pulse times.
    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            cyc++;
            if (minute_set === 1'b1) q_min.push_back(cyc);
            if (hour_set === 1'b1)   q_hr.push_back(cyc);
        end
    endtask

    task automatic start_scenario();
        cyc = 0;
        q_min.delete();
        q_hr.delete();
    endtask

    initial begin
        reset     = 1'b0;
        key_mode  = 1'b1;
        key_field = 1'b1;
        key_inc   = 1'b1;
        key_onoff = 1'b1;
        watch(3);
        check("rst_mode", 32'(mode), 0);
        check("rst_set", 32'(set), 0);
        check("rst_alerm", 32'(alerm), 0);
        check("rst_min", 32'(minute_set), 0);
        check("rst_hour", 32'(hour_set), 0);
        check("rst_sw", 32'(alerm_switch), 0);
        reset = 1'b1;
        watch(10);

        // Mode stepping RUN->SET->ALARM->RUN, change 7 cycles after press
        start_scenario();
        key_mode = 1'b0;
        watch(6);
        check("m1_early", 32'(mode), 0);
        watch(1);
        check("m1_mode", 32'(mode), 1);
        check("m1_set", 32'(set), 1);
        check("m1_alerm", 32'(alerm), 0);
        key_mode = 1'b1;
        watch(10);
        start_scenario();
        key_mode = 1'b0;
        watch(7);
        check("m2_mode", 32'(mode), 2);
        check("m2_set", 32'(set), 0);
        check("m2_alerm", 32'(alerm), 1);
        key_mode = 1'b1;
        watch(10);
        start_scenario();
        key_mode = 1'b0;
        watch(6);
        check("m3_early", 32'(mode), 2);
        watch(1);
        check("m3_mode", 32'(mode), 0);
        check("m3_set", 32'(set), 0);
        check("m3_alerm", 32'(alerm), 0);
        key_mode = 1'b1;
        watch(10);

        // Increment held in RUN is suppressed
        start_scenario();
        key_inc = 1'b0;
        watch(30);
        key_inc = 1'b1;
        watch(10);
        check("run_inc_min", q_min.size(), 0);
        check("run_inc_hr", q_hr.size(), 0);

        // Alarm enable toggles in RUN
        start_scenario();
        key_onoff = 1'b0;
        watch(6);
        check("onoff_early", 32'(alerm_switch), 0);
        watch(1);
        check("onoff_on", 32'(alerm_switch), 1);
        key_onoff = 1'b1;
        watch(10);

        // Enter SET, bounce key_inc, then hold 40 cycles for auto-repeat
        start_scenario();
        key_mode = 1'b0;
        watch(7);
        check("set_entry", 32'(mode), 1);
        key_mode = 1'b1;
        watch(8);
        for (int b = 0; b < 3; b++) begin
            key_inc = 1'b0;
            watch(3);
            key_inc = 1'b1;
            watch(2);
        end
        start_scenario();
        key_inc = 1'b0;
        watch(40);
        key_inc = 1'b1;
        watch(20);
        check("rep_count", q_min.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < q_min.size()) check("rep_time", q_min[k], exp_rep[k]);
        end
        check("rep_hour", q_hr.size(), 0);
        // Idle timeout measured from the increment event at cycle 7
        watch(47);
        check("idle_before", 32'(mode), 1);
        watch(1);
        check("idle_timeout", 32'(mode), 0);
        check("idle_set", 32'(set), 0);

        // Increment event 2 cycles after a mode change is in the hold-off
        start_scenario();
        key_mode = 1'b0;
        watch(2);
        key_inc = 1'b0;
        watch(5);
        check("hold2_mode", 32'(mode), 1);
        watch(23);
        check("hold2_min", q_min.size(), 0);
        check("hold2_hr", q_hr.size(), 0);
        key_mode = 1'b1;
        key_inc  = 1'b1;
        watch(10);

        // Increment event 3 cycles after a mode change passes (field cleared)
        start_scenario();
        key_mode = 1'b0;
        watch(3);
        key_inc = 1'b0;
        watch(4);
        check("hold3_mode", 32'(mode), 2);
        watch(5);
        key_inc  = 1'b1;
        key_mode = 1'b1;
        watch(25);
        check("hold3_count", q_min.size(), 1);
        if (q_min.size() > 0) check("hold3_time", q_min[0], 10);
        check("hold3_hr", q_hr.size(), 0);

        // In ALARM: toggle field to hour, then increment
        key_field = 1'b0;
        watch(8);
        key_field = 1'b1;
        watch(8);
        start_scenario();
        key_inc = 1'b0;
        watch(8);
        key_inc = 1'b1;
        watch(25);
        check("hr_count", q_hr.size(), 1);
        if (q_hr.size() > 0) check("hr_time", q_hr[0], 7);
        check("hr_min", q_min.size(), 0);

        // Back to RUN, then SET, then simultaneous mode+inc
        key_mode = 1'b0;
        watch(7);
        check("back_run", 32'(mode), 0);
        key_mode = 1'b1;
        watch(10);
        key_mode = 1'b0;
        watch(7);
        check("back_set", 32'(mode), 1);
        key_mode = 1'b1;
        watch(10);
        start_scenario();
        key_mode = 1'b0;
        key_inc  = 1'b0;
        watch(7);
        check("sim_mode", 32'(mode), 2);
        watch(23);
        key_mode = 1'b1;
        key_inc  = 1'b1;
        watch(10);
        check("sim_min", q_min.size(), 0);
        check("sim_hr", q_hr.size(), 0);

        // Reset in the middle of an auto-repeat while key_inc is held
        start_scenario();
        key_inc = 1'b0;
        watch(30);
        check("pre_rst_count", q_min.size(), 2);
        if (q_min.size() > 1) check("pre_rst_time", q_min[1], 27);
        reset = 1'b0;
        #1;
        check("mid_rst_mode", 32'(mode), 0);
        check("mid_rst_alerm", 32'(alerm), 0);
        check("mid_rst_min", 32'(minute_set), 0);
        check("mid_rst_sw", 32'(alerm_switch), 0);
        watch(3);
        reset = 1'b1;
        start_scenario();
        watch(10);
        key_mode = 1'b0;
        watch(7);
        check("post_rst_set", 32'(mode), 1);
        key_mode = 1'b1;
        watch(30);
        check("post_rst_min", q_min.size(), 0);
        key_inc = 1'b1;
        watch(10);
        start_scenario();
        key_inc = 1'b0;
        watch(10);
        check("repress_count", q_min.size(), 1);
        if (q_min.size() > 0) check("repress_time", q_min[0], 7);
        key_inc = 1'b1;
        watch(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
